// File: rtl/pipe_reg_skid_pkg.sv
// Shared definitions for the skid-buffered pipeline stage register.
package pipe_pkg;

    // Encoding is {s_valid, m_valid}; 2'b10 is unreachable by construction.
    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'b00,
        PIPE_ONE   = 2'b01,
        PIPE_TWO   = 2'b11
    } pipe_state_e;

    localparam logic PIPE_RST_BIT = 1'b0;

endpackage

// File: rtl/pipe_reg_skid_if.sv
// Handshake bundle between upstream, the stage register and downstream.
interface pipe_reg_skid_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    // master = surrounding pipeline (both neighbours), slave = the stage itself
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );
    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_reg_skid_register_nbit.sv
// Enable/clear register of arbitrary width; clr is asynchronous.
module register_nbit #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] in,
    input  logic             clk,
    input  logic             en,
    input  logic             clr
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr)     out <= RESET_VALUE;
        else if (en) out <= in;
    end

endmodule

// File: rtl/pipe_reg_skid.sv
// Pipeline stage register with registered ready and one-entry skid buffer.
module pipe_reg_skid
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{PIPE_RST_BIT}}
) (
    input  logic           clk,
    input  logic           clr,
    pipe_reg_skid_if.slave bus
);

    pipe_state_e      state_q, state_d;
    logic             m_en, s_en, m_from_s;
    logic             accept, pop;
    logic [WIDTH-1:0] m_data, s_data, m_din;

    assign bus.in_ready  = ~state_q[1];
    assign bus.out_valid = state_q[0];
    assign bus.out_data  = m_data;
    assign bus.occupancy = {1'b0, state_q[1]} + {1'b0, state_q[0]};

    assign accept = bus.in_valid & bus.in_ready;
    assign pop    = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state_q <= PIPE_EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        m_en     = 1'b0;
        s_en     = 1'b0;
        m_from_s = 1'b0;
        case (state_q)
            PIPE_EMPTY: begin
                if (accept) begin
                    state_d = PIPE_ONE;
                    m_en    = 1'b1;
                end
            end
            PIPE_ONE: begin
                if (accept && pop) begin
                    m_en    = 1'b1;
                end else if (accept) begin
                    state_d = PIPE_TWO;
                    s_en    = 1'b1;
                end else if (pop) begin
                    state_d = PIPE_EMPTY;
                end
            end
            PIPE_TWO: begin
                if (pop) begin
                    state_d  = PIPE_ONE;
                    m_en     = 1'b1;
                    m_from_s = 1'b1;
                end
            end
            default: state_d = PIPE_EMPTY;
        endcase
        // Flush drops everything held; a same-cycle pop has already been seen downstream.
        if (bus.flush) begin
            state_d = PIPE_EMPTY;
            m_en    = 1'b0;
            s_en    = 1'b0;
        end
    end

    assign m_din = m_from_s ? s_data : bus.in_data;

    register_nbit #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_m_data (
        .out (m_data),
        .in  (m_din),
        .clk (clk),
        .en  (m_en),
        .clr (clr)
    );

    register_nbit #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_s_data (
        .out (s_data),
        .in  (bus.in_data),
        .clk (clk),
        .en  (s_en),
        .clr (clr)
    );

endmodule
